fifo_flow_ctrl_fsm: RTL and testbench
=====================================

Name: fifo_flow_ctrl_fsm

Overview:
- Parametrised control FSM for a bank of NUM_CH FIFOs; next generation of the team's RESET/INIT/IDLE/ACTIVE controller.
- Captures high/low thresholds on init and tracks aggregate activity from per-channel occupancy counts.
- Generates per-channel almost-full/almost-empty flags and a hysteretic pause for upstream flow control.
- Adds a sticky ERROR state for FIFO overflow/underflow and for invalid threshold programming.

Parameters:
- NUM_CH, 8, number of FIFO channels monitored.
- CNT_W, 4, width of each occupancy count and of each threshold.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- init  input  1  load thresholds and enter INIT; level-sensitive.
- high_thr  input  CNT_W  almost-full threshold, sampled when init=1.
- low_thr  input  CNT_W  almost-empty threshold, sampled when init=1.
- fifo_count  input  NUM_CH*CNT_W  occupancy of each channel; channel i is bits [i*CNT_W +: CNT_W].
- fifo_ovf  input  NUM_CH  per-channel push-while-full pulse.
- fifo_udf  input  NUM_CH  per-channel pop-while-empty pulse.
- sup_thr  output  CNT_W  registered high threshold.
- inf_thr  output  CNT_W  registered low threshold.
- state  output  5  one-hot current state.
- almost_full  output  NUM_CH  per-channel flag, registered.
- almost_empty  output  NUM_CH  per-channel flag, registered.
- pause  output  1  upstream stall request with hysteresis, registered.
- err_vec  output  NUM_CH  sticky per-channel error record.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- State encodings: RESET=5'b00001, INIT=5'b00010, IDLE=5'b00100, ACTIVE=5'b01000, ERROR=5'b10000.
- Reset: on a clock edge with reset=1, all registers clear: state=RESET, sup_thr=0, inf_thr=0, almost_full=0, almost_empty=0, pause=0, err_vec=0.
- Priority per edge: reset > init > error detection > normal transition.
- init=1:
  - Next state is INIT from any state.
  - sup_thr<=high_thr, inf_thr<=low_thr.
  - err_vec cleared and pause cleared.
  - Holding init high keeps the FSM in INIT and reloads the thresholds every cycle.
- RESET -> INIT unconditionally on the next edge; thresholds stay 0.
- INIT -> ERROR if inf_thr > sup_thr (unsigned compare); otherwise INIT -> IDLE. Equal thresholds are legal.
- Error detection: in IDLE or ACTIVE, if |(fifo_ovf|fifo_udf) is set, next state is ERROR and err_vec |= fifo_ovf|fifo_udf.
- Error inputs are ignored in RESET and INIT.
- Error inputs keep OR-ing into err_vec while in ERROR.
- IDLE -> ACTIVE when any channel count != 0; otherwise stay IDLE.
- ACTIVE -> IDLE when all counts == 0; otherwise stay ACTIVE.
- ERROR is sticky; only init or reset leaves it.
- Flags (IDLE/ACTIVE only; forced 0 in RESET/INIT/ERROR):
  - almost_full[i] <= (count_i >= sup_thr).
  - almost_empty[i] <= (count_i <= inf_thr).
  - Both flags update one cycle after the count is sampled.
- pause (IDLE/ACTIVE only; forced 0 elsewhere):
  - Set when any count_i >= sup_thr.
  - Cleared when every count_i <= inf_thr.
  - Otherwise holds its value (hysteresis band).
  - Set takes priority if both conditions are true, which is possible when sup_thr <= inf_thr.
- All comparisons are unsigned at CNT_W bits; no count saturation or wrap handling is done here.
- state output is the registered current state with no combinational bypass.

Decomposition:
- Shared package fifo_ctrl_pkg: the five one-hot state constants, state width 5, default NUM_CH and CNT_W.
- One sub-module, fifo_ch_thr_cmp: per-channel comparator producing ge_high, le_low and nonzero for one count; instantiated NUM_CH times with a generate loop.
- FSM, threshold registers, pause hysteresis and err_vec live in the top module.

Test Plan:
- Reset: hold reset 2 cycles, then release -> state=RESET for one cycle, then INIT; with init=0, thresholds are 0 and then IDLE.
- Init/activity: init=1 for 1 cycle with high=6, low=2, all counts 0 -> INIT, then IDLE; sup_thr=6, inf_thr=2. Set ch3 count=1 -> ACTIVE on the next edge; all counts 0 -> IDLE.
- Hysteresis: ch0 count steps 0,3,6,5,3,2 -> almost_full goes 1 one cycle after the count reaches 6. pause rises then, holds through 5 and 3, and clears the cycle after the count reaches 2.
- Error: in ACTIVE, pulse fifo_ovf[5] and fifo_udf[1] in the same cycle -> ERROR next cycle, err_vec=8'b00100010, pause=0, flags=0. ERROR persists with counts changing; init recovers to INIT then IDLE with err_vec=0.
- Invalid thresholds: init with high=2, low=5 -> INIT, then ERROR, err_vec=0. Reinit with high=5, low=2 -> IDLE.
- Mid-operation control: reset asserted mid-ACTIVE with pause=1 -> all outputs cleared at the next edge. init asserted simultaneously with fifo_ovf in IDLE -> INIT wins and err_vec=0.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO flow-control controller: one-hot state
// encodings and default bank dimensions.
package fifo_ctrl_pkg;

    localparam int STATE_W    = 5;
    localparam int DEF_NUM_CH = 8;
    localparam int DEF_CNT_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_e;

endpackage

// File: rtl/fifo_ch_thr_cmp.sv
// Per-channel occupancy comparator: unsigned compare of one count against
// the registered high/low thresholds, plus a non-empty indication.
module fifo_ch_thr_cmp #(
    parameter int CNT_W = 4
) (
    input  logic [CNT_W-1:0] count,
    input  logic [CNT_W-1:0] sup_thr,
    input  logic [CNT_W-1:0] inf_thr,
    output logic             ge_high,
    output logic             le_low,
    output logic             nonzero
);

    assign ge_high = (count >= sup_thr);
    assign le_low  = (count <= inf_thr);
    assign nonzero = (count != {CNT_W{1'b0}});

endmodule

// File: rtl/fifo_flow_ctrl_fsm.sv
// Control FSM for a bank of FIFOs: threshold capture, activity tracking,
// per-channel almost-full/empty flags, hysteretic pause and sticky errors.
module fifo_flow_ctrl_fsm
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [CNT_W-1:0]        high_thr,
    input  logic [CNT_W-1:0]        low_thr,
    input  logic [NUM_CH*CNT_W-1:0] fifo_count,
    input  logic [NUM_CH-1:0]       fifo_ovf,
    input  logic [NUM_CH-1:0]       fifo_udf,
    output logic [CNT_W-1:0]        sup_thr,
    output logic [CNT_W-1:0]        inf_thr,
    output logic [STATE_W-1:0]      state,
    output logic [NUM_CH-1:0]       almost_full,
    output logic [NUM_CH-1:0]       almost_empty,
    output logic                    pause,
    output logic [NUM_CH-1:0]       err_vec
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   sup_thr_q, sup_thr_d;
    logic [CNT_W-1:0]   inf_thr_q, inf_thr_d;
    logic [NUM_CH-1:0]  almost_full_q, almost_full_d;
    logic [NUM_CH-1:0]  almost_empty_q, almost_empty_d;
    logic               pause_q, pause_d;
    logic [NUM_CH-1:0]  err_vec_q, err_vec_d;

    logic [NUM_CH-1:0]  ge_high_s;
    logic [NUM_CH-1:0]  le_low_s;
    logic [NUM_CH-1:0]  nonzero_s;
    logic [NUM_CH-1:0]  err_in_s;
    logic               run_next_s;

    assign err_in_s = fifo_ovf | fifo_udf;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cmp
        fifo_ch_thr_cmp #(.CNT_W(CNT_W)) u_cmp (
            .count   (fifo_count[g*CNT_W +: CNT_W]),
            .sup_thr (sup_thr_q),
            .inf_thr (inf_thr_q),
            .ge_high (ge_high_s[g]),
            .le_low  (le_low_s[g]),
            .nonzero (nonzero_s[g])
        );
    end

    // Next-state, threshold and error-record logic
    always_comb begin
        state_d   = state_q;
        sup_thr_d = sup_thr_q;
        inf_thr_d = inf_thr_q;
        err_vec_d = err_vec_q;
        if (init) begin
            state_d   = ST_INIT;
            sup_thr_d = high_thr;
            inf_thr_d = low_thr;
            err_vec_d = {NUM_CH{1'b0}};
        end else begin
            case (state_q)
                ST_RESET: state_d = ST_INIT;
                ST_INIT: begin
                    if (inf_thr_q > sup_thr_q) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_IDLE, ST_ACTIVE: begin
                    if (|err_in_s) begin
                        state_d   = ST_ERROR;
                        err_vec_d = err_vec_q | err_in_s;
                    end else if (|nonzero_s) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ERROR: begin
                    state_d   = ST_ERROR;
                    err_vec_d = err_vec_q | err_in_s;
                end
                default: state_d = ST_RESET;
            endcase
        end
    end

    // Flags and pause follow the state being entered, so leaving IDLE/ACTIVE
    // clears them on the same edge; set wins over clear inside the band.
    assign run_next_s = (state_d == ST_IDLE) || (state_d == ST_ACTIVE);

    // Flag and pause hysteresis logic
    always_comb begin
        almost_full_d  = {NUM_CH{1'b0}};
        almost_empty_d = {NUM_CH{1'b0}};
        pause_d        = 1'b0;
        if (run_next_s) begin
            almost_full_d  = ge_high_s;
            almost_empty_d = le_low_s;
            if (|ge_high_s) begin
                pause_d = 1'b1;
            end else if (&le_low_s) begin
                pause_d = 1'b0;
            end else begin
                pause_d = pause_q;
            end
        end else begin
            pause_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RESET;
            sup_thr_q      <= {CNT_W{1'b0}};
            inf_thr_q      <= {CNT_W{1'b0}};
            almost_full_q  <= {NUM_CH{1'b0}};
            almost_empty_q <= {NUM_CH{1'b0}};
            pause_q        <= 1'b0;
            err_vec_q      <= {NUM_CH{1'b0}};
        end else begin
            state_q        <= state_d;
            sup_thr_q      <= sup_thr_d;
            inf_thr_q      <= inf_thr_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            pause_q        <= pause_d;
            err_vec_q      <= err_vec_d;
        end
    end

    assign state        = state_q;
    assign sup_thr      = sup_thr_q;
    assign inf_thr      = inf_thr_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign pause        = pause_q;
    assign err_vec      = err_vec_q;

endmodule

// File: tb/tb_fifo_flow_ctrl_fsm.sv
// Directed bench for fifo_flow_ctrl_fsm with hand-computed expectations
// (NUM_CH=8, CNT_W=4).
module tb_fifo_flow_ctrl_fsm;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 4;

    localparam logic [4:0] S_RESET  = 5'b00001;
    localparam logic [4:0] S_INIT   = 5'b00010;
    localparam logic [4:0] S_IDLE   = 5'b00100;
    localparam logic [4:0] S_ACTIVE = 5'b01000;
    localparam logic [4:0] S_ERROR  = 5'b10000;

    logic                    clk;
    logic                    reset;
    logic                    init;
    logic [CNT_W-1:0]        high_thr;
    logic [CNT_W-1:0]        low_thr;
    logic [NUM_CH*CNT_W-1:0] fifo_count;
    logic [NUM_CH-1:0]       fifo_ovf;
    logic [NUM_CH-1:0]       fifo_udf;
    logic [CNT_W-1:0]        sup_thr;
    logic [CNT_W-1:0]        inf_thr;
    logic [4:0]              state;
    logic [NUM_CH-1:0]       almost_full;
    logic [NUM_CH-1:0]       almost_empty;
    logic                    pause;
    logic [NUM_CH-1:0]       err_vec;

    int total;
    int bad;

    fifo_flow_ctrl_fsm #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .high_thr     (high_thr),
        .low_thr      (low_thr),
        .fifo_count   (fifo_count),
        .fifo_ovf     (fifo_ovf),
        .fifo_udf     (fifo_udf),
        .sup_thr      (sup_thr),
        .inf_thr      (inf_thr),
        .state        (state),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .pause        (pause),
        .err_vec      (err_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [4:0] st, input logic [7:0] af,
                           input logic [7:0] ae, input logic pz, input logic [7:0] ev);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".af"}, 32'(almost_full), 32'(af));
        chk({tag, ".ae"}, 32'(almost_empty), 32'(ae));
        chk({tag, ".pause"}, 32'(pause), 32'(pz));
        chk({tag, ".err"}, 32'(err_vec), 32'(ev));
    endtask

    task automatic set_ch(input int ch, input logic [CNT_W-1:0] v);
        fifo_count[ch*CNT_W +: CNT_W] = v;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        init       = 1'b0;
        high_thr   = 4'd0;
        low_thr    = 4'd0;
        fifo_count = 32'd0;
        fifo_ovf   = 8'd0;
        fifo_udf   = 8'd0;

        // reset held two cycles
        step();
        step();
        chk_out("rst", S_RESET, 8'h00, 8'h00, 1'b0, 8'h00);
        chk("rst.sup", 32'(sup_thr), 32'd0);
        chk("rst.inf", 32'(inf_thr), 32'd0);
        reset = 1'b0;
        step();
        chk_out("rst_init", S_INIT, 8'h00, 8'h00, 1'b0, 8'h00);
        step();
        // zero thresholds: every count 0 satisfies both compares; set wins
        chk_out("rst_idle", S_IDLE, 8'hff, 8'hff, 1'b1, 8'h00);

        // init with high=6 low=2
        init = 1'b1; high_thr = 4'd6; low_thr = 4'd2;
        step();
        chk_out("init", S_INIT, 8'h00, 8'h00, 1'b0, 8'h00);
        chk("init.sup", 32'(sup_thr), 32'd6);
        chk("init.inf", 32'(inf_thr), 32'd2);
        init = 1'b0;
        step();
        chk_out("idle", S_IDLE, 8'h00, 8'hff, 1'b0, 8'h00);

        // activity on channel 3
        set_ch(3, 4'd1);
        step();
        chk_out("act", S_ACTIVE, 8'h00, 8'hff, 1'b0, 8'h00);
        set_ch(3, 4'd0);
        step();
        chk("act_idle.state", 32'(state), 32'(S_IDLE));

        // hysteresis on channel 0
        set_ch(0, 4'd3);
        step();
        chk_out("hys3a", S_ACTIVE, 8'h00, 8'hfe, 1'b0, 8'h00);
        set_ch(0, 4'd6);
        step();
        chk_out("hys6", S_ACTIVE, 8'h01, 8'hfe, 1'b1, 8'h00);
        set_ch(0, 4'd5);
        step();
        chk_out("hys5", S_ACTIVE, 8'h00, 8'hfe, 1'b1, 8'h00);
        set_ch(0, 4'd3);
        step();
        chk_out("hys3b", S_ACTIVE, 8'h00, 8'hfe, 1'b1, 8'h00);
        set_ch(0, 4'd2);
        step();
        chk_out("hys2", S_ACTIVE, 8'h00, 8'hff, 1'b0, 8'h00);

        // overflow/underflow in ACTIVE
        set_ch(0, 4'd6);
        step();
        chk("pre_err.pause", 32'(pause), 32'd1);
        fifo_ovf = 8'h20; fifo_udf = 8'h02;
        step();
        chk_out("err", S_ERROR, 8'h00, 8'h00, 1'b0, 8'h22);
        fifo_ovf = 8'h00; fifo_udf = 8'h00;
        set_ch(0, 4'd9);
        step();
        chk_out("err_hold", S_ERROR, 8'h00, 8'h00, 1'b0, 8'h22);
        fifo_ovf = 8'h80;
        step();
        chk("err_or", 32'(err_vec), 32'h0a2);
        fifo_ovf = 8'h00;
        init = 1'b1; high_thr = 4'd6; low_thr = 4'd2;
        set_ch(0, 4'd0);
        step();
        chk_out("err_rec", S_INIT, 8'h00, 8'h00, 1'b0, 8'h00);
        init = 1'b0;
        step();
        chk_out("err_rec_idle", S_IDLE, 8'h00, 8'hff, 1'b0, 8'h00);

        // invalid thresholds
        init = 1'b1; high_thr = 4'd2; low_thr = 4'd5;
        step();
        chk("bad_thr.state", 32'(state), 32'(S_INIT));
        init = 1'b0;
        step();
        chk_out("bad_thr", S_ERROR, 8'h00, 8'h00, 1'b0, 8'h00);
        init = 1'b1; high_thr = 4'd5; low_thr = 4'd2;
        step();
        init = 1'b0;
        step();
        chk("reinit.state", 32'(state), 32'(S_IDLE));

        // equal thresholds are legal; set has priority when both hold
        init = 1'b1; high_thr = 4'd3; low_thr = 4'd3;
        step();
        init = 1'b0;
        step();
        chk_out("eq_idle", S_IDLE, 8'h00, 8'hff, 1'b0, 8'h00);
        set_ch(0, 4'd3);
        step();
        chk_out("eq_both", S_ACTIVE, 8'h01, 8'hff, 1'b1, 8'h00);

        // reset mid-ACTIVE with pause high
        set_ch(0, 4'd6);
        step();
        chk("mid.pause", 32'(pause), 32'd1);
        reset = 1'b1;
        set_ch(0, 4'd0);
        step();
        chk_out("mid_rst", S_RESET, 8'h00, 8'h00, 1'b0, 8'h00);
        chk("mid_rst.sup", 32'(sup_thr), 32'd0);
        reset = 1'b0;
        step();
        step();
        chk("mid_idle.state", 32'(state), 32'(S_IDLE));

        // init coinciding with overflow in IDLE
        init = 1'b1; high_thr = 4'd6; low_thr = 4'd2; fifo_ovf = 8'h01;
        step();
        chk_out("init_vs_ovf", S_INIT, 8'h00, 8'h00, 1'b0, 8'h00);
        init = 1'b0; fifo_ovf = 8'h00;
        step();
        chk_out("init_vs_ovf_idle", S_IDLE, 8'h00, 8'hff, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
